pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, meaning PC/address width in bits (>= 8).
REQ-002 Parameter RESET_VEC, default 32'h0000_3000, meaning first fetch address after reset (ADDR_W bits).
REQ-003 Parameter BTB_ENTRIES, default 8, meaning BTB entry count (power of 2, 2..64); unused when PC_BTB_EN is undefined.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall_i  in  1  fetch stage stall; 1 = hold PC.
REQ-007 flush_i  in  1  exception flush request.
REQ-008 new_pc_i  in  ADDR_W  exception handler address.
REQ-009 redirect_i  in  1  branch-resolution redirect (mispredict or taken correction).
REQ-010 redirect_pc_i  in  ADDR_W  correct next-fetch address.
REQ-011 upd_valid_i  in  1  resolved control-flow instruction update strobe.
REQ-012 upd_pc_i / upd_target_i  in  ADDR_W each  resolved branch PC / target.
REQ-013 upd_taken_i  in  1  resolved direction.
REQ-014 pc_o  out  ADDR_W  current fetch address (registered).
REQ-015 ce_o  out  1  instruction memory chip enable (registered).
REQ-016 pred_taken_o  out  1  prediction for pc_o (combinational from pc_o and BTB state).
REQ-017 pred_target_o  out  ADDR_W  predicted next PC for pc_o.

Function
REQ-018 Two-state FSM: IDLE (ce_o=0) and RUN (ce_o=1); IDLE->RUN on first clock with rst=0; any state->IDLE on rst=1.
REQ-019 In IDLE, pc_o SHALL load RESET_VEC every clock; all other inputs ignored.
REQ-020 In RUN, next-PC priority per clock: flush_i > redirect_i > pending redirect > stall_i hold > prediction > pc_o+4.
REQ-021 flush_i=1 loads new_pc_i regardless of stall_i and clears any pending redirect.
REQ-022 redirect_i=1 with stall_i=0 loads redirect_pc_i next clock.
REQ-023 redirect_i=1 with stall_i=1 captures redirect_pc_i into a one-entry pending register (newer overwrites older); pc_o holds.
REQ-024 Pending redirect is applied on the first clock with stall_i=0, then cleared.
REQ-025 Sequential increment pc_o+4 wraps modulo 2^ADDR_W; addresses are not realigned.
REQ-026 Latency: every PC change is visible on pc_o exactly one clock after the deciding edge; no combinational path from inputs to pc_o.
REQ-027 When not predicting, pred_taken_o=0 and pred_target_o=pc_o+4.

Reset
REQ-028 rst=1 at any clock: ce_o=0, pc_o=RESET_VEC, pending redirect cleared, all BTB valid bits cleared, next clock; rst mid-stall or mid-redirect discards that operation.
REQ-029 First clock after rst deasserts: ce_o=1, pc_o still RESET_VEC; sequencing starts the following clock.

Configuration
REQ-030 Macro PC_BTB_EN: defined -> direct-mapped BTB compiled in; undefined -> no BTB storage, pred_taken_o tied 0, upd_* ignored, next-PC omits prediction.
REQ-031 BTB index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits; entry = valid, tag, target, 2-bit saturating counter.
REQ-032 Prediction: hit (valid and tag match) with counter >= 2 -> pred_taken_o=1, pred_target_o=entry target, used as next PC when no higher-priority event.
REQ-033 Update on upd_valid_i: hit -> counter +1 if taken, -1 if not, saturating at 3/0, target rewritten if taken; miss and taken -> allocate with counter=2; miss and not taken -> no change.
REQ-034 Same-clock lookup and update to one entry: lookup uses pre-update contents.

Structure
REQ-035 Shared package holds RESET_VEC default, FSM state encoding, counter constants (2'b00..2'b11, allocate value 2'b10).
REQ-036 BTB is one sub-module pc_btb (lookup port + update port); pc_gen instantiates it only when PC_BTB_EN is defined.

Verification
REQ-037 rst 3 clocks then release -> ce_o 0,0,0,1; pc_o 0x3000, 0x3000, then 0x3004, 0x3008.
REQ-038 RUN at 0x3010, stall_i=1 two clocks with redirect_i=1 redirect_pc_i=0x3100 in first -> pc_o holds 0x3010, then 0x3100 one clock after stall drops.
REQ-039 flush_i=1 new_pc_i=0x20, redirect_i=1 to 0x4000, stall_i=1 same clock -> pc_o=0x20, pending cleared, next 0x24.
REQ-040 pc_o=0xFFFF_FFFC, no events -> next pc_o=0x0000_0000.
REQ-041 PC_BTB_EN: update pc 0x3008 taken target 0x3200 -> next fetch of 0x3008 gives pred_taken_o=1, pc_o 0x3200; two not-taken updates -> counter 0, fetch goes 0x300C.
REQ-042 PC_BTB_EN undefined: same stimulus as REQ-041 -> pred_taken_o=0 always, 0x3008 followed by 0x300C.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator: reset vector, FSM encoding, BTB counter values.
package pc_gen_pkg;

  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_ALLOC = 2'b10;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on pre-update contents; update is registered.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc_i,
  output logic              lk_taken_o,
  output logic [ADDR_W-1:0] lk_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [ADDR_W-1:0]  target [ENTRIES];
  logic [1:0]         cnt    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic             unused_lsb;

  assign lk_idx  = lk_pc_i[IDX_W+1:2];
  assign lk_tag  = lk_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign unused_lsb = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_hit      = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign lk_taken_o  = lk_hit && (cnt[lk_idx] >= CNT_WT);
  assign lk_target_o = target[lk_idx];

  assign upd_hit = valid[upd_idx] && (tag[upd_idx] == upd_tag);

  // Training: saturating counter on hit, allocate weakly-taken on a taken miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          target[upd_idx] <= upd_target_i;
          if (cnt[upd_idx] != CNT_ST) cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
        end else if (cnt[upd_idx] != CNT_SNT) begin
          cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        valid[upd_idx]  <= 1'b1;
        tag[upd_idx]    <= upd_tag;
        target[upd_idx] <= upd_target_i;
        cnt[upd_idx]    <= CNT_ALLOC;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: flush / redirect / pending redirect / stall / prediction / pc+4.
// Optional BTB prediction is compiled in with `define PC_BTB_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(PC_RESET_VEC_DEF),
  parameter int unsigned       BTB_ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o
);

  logic [0:0]        state, state_n;
  logic [ADDR_W-1:0] pc_n, pend_pc, pend_pc_n, seq_pc;
  logic              ce_n, pend_valid, pend_valid_n;

  assign seq_pc = pc_o + ADDR_W'(4);

`ifdef PC_BTB_EN
  logic              btb_taken;
  logic [ADDR_W-1:0] btb_target;

  pc_btb #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lk_pc_i      (pc_o),
    .lk_taken_o   (btb_taken),
    .lk_target_o  (btb_target),
    .upd_valid_i  (upd_valid_i && (state == ST_RUN)),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .upd_taken_i  (upd_taken_i)
  );

  assign pred_taken_o  = btb_taken;
  assign pred_target_o = btb_taken ? btb_target : seq_pc;
`else
  logic unused_upd;

  assign unused_upd    = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
                           (BTB_ENTRIES == 0)};
  assign pred_taken_o  = 1'b0;
  assign pred_target_o = seq_pc;
`endif

  // Next-state and next-PC selection in priority order.
  always_comb begin
    state_n      = state;
    pc_n         = pc_o;
    ce_n         = ce_o;
    pend_valid_n = pend_valid;
    pend_pc_n    = pend_pc;
    case (state)
      ST_IDLE: begin
        state_n      = ST_RUN;
        ce_n         = 1'b1;
        pc_n         = RESET_VEC;
        pend_valid_n = 1'b0;
      end
      ST_RUN: begin
        ce_n = 1'b1;
        if (flush_i) begin
          pc_n         = new_pc_i;
          pend_valid_n = 1'b0;
        end else if (redirect_i) begin
          if (stall_i) begin
            pend_valid_n = 1'b1;
            pend_pc_n    = redirect_pc_i;
          end else begin
            pc_n         = redirect_pc_i;
            pend_valid_n = 1'b0;
          end
        end else if (pend_valid && !stall_i) begin
          pc_n         = pend_pc;
          pend_valid_n = 1'b0;
        end else if (!stall_i) begin
          pc_n = pred_target_o;
        end
      end
      default: begin
        state_n      = ST_IDLE;
        ce_n         = 1'b0;
        pc_n         = RESET_VEC;
        pend_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc_o       <= RESET_VEC;
      ce_o       <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_n;
      pc_o       <= pc_n;
      ce_o       <= ce_n;
      pend_valid <= pend_valid_n;
      pend_pc    <= pend_pc_n;
    end
  end

endmodule
